// File: rtl/udp_segmenter.sv
// udp_segmenter: splits frames into header-regenerated segments of at most MAX_SEG bytes,
// with a store-and-forward length stream alongside the byte stream.
module udp_segmenter #(
    parameter int MAX_SEG    = 1024,
    parameter int DATA_DEPTH = 4096,
    parameter int LEN_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        length_tvalid,
    input  logic        length_tready,
    output logic [15:0] length_tdata,
    output logic [15:0] runt_count
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int LAW = LEN_DEPTH > 1 ? $clog2(LEN_DEPTH) : 1;

    generate
        if (DATA_DEPTH < MAX_SEG || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0 ||
            (LEN_DEPTH & (LEN_DEPTH - 1)) != 0 || MAX_SEG < 3 || MAX_SEG > 65535) begin : g_bad_param
            $error("udp_segmenter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {SRC, SEQ, PAY, INS_SRC, INS_SEQ} state_t;
    state_t state, state_nx;

    logic [7:0]  src, seq, wdat;
    logic [15:0] seg_cnt;
    logic        wr, wlast, runt, ok, acc, full_seg, dpop, lpop, len_wr;

    logic [8:0]     dmem [DATA_DEPTH];
    logic [DAW-1:0] dwp, drp;
    logic [DAW:0]   dcnt;
    logic [15:0]    lmem [LEN_DEPTH];
    logic [LAW-1:0] lwp, lrp;
    logic [LAW:0]   lcnt;

    // Write enable looks at full only, so a pop in the same cycle never frees room early.
    assign ok       = resetn && dcnt != (DAW+1)'(DATA_DEPTH) && lcnt != (LAW+1)'(LEN_DEPTH);
    assign acc      = s_tvalid && ok;
    assign full_seg = seg_cnt == 16'(MAX_SEG - 1);
    assign len_wr   = wr && wlast;

    always_comb begin
        state_nx = state;
        s_tready = 1'b0;
        wr       = 1'b0;
        wdat     = 8'h00;
        wlast    = 1'b0;
        runt     = 1'b0;
        case (state)
            SRC: begin
                s_tready = ok;
                wdat     = s_tdata;
                wr       = acc && !s_tlast;
                runt     = acc && s_tlast;
                state_nx = wr ? SEQ : SRC;
            end
            SEQ: begin
                s_tready = ok;
                wr       = acc;
                wlast    = s_tlast;
                state_nx = !acc ? SEQ : s_tlast ? SRC : PAY;
            end
            PAY: begin
                s_tready = ok;
                wr       = acc;
                wdat     = s_tdata;
                wlast    = s_tlast || full_seg;
                state_nx = !acc ? PAY : s_tlast ? SRC : full_seg ? INS_SRC : PAY;
            end
            INS_SRC: begin
                wr       = ok;
                wdat     = src;
                state_nx = ok ? INS_SEQ : INS_SRC;
            end
            INS_SEQ: begin
                wr       = ok;
                wdat     = seq + 8'd1;
                state_nx = ok ? PAY : INS_SEQ;
            end
            default: state_nx = SRC;
        endcase
    end

    assign dpop          = m_tvalid && m_tready;
    assign lpop          = length_tvalid && length_tready;
    assign m_tvalid      = dcnt != '0;
    assign m_tdata       = dmem[drp][7:0];
    assign m_tlast       = m_tvalid && dmem[drp][8];
    assign length_tvalid = lcnt != '0;
    assign length_tdata  = lmem[lrp];

    always_ff @(posedge clk) begin
        if (wr)
            dmem[dwp] <= {wlast, wdat};
        if (len_wr)
            lmem[lwp] <= seg_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= SRC;
            src        <= 8'h00;
            seq        <= 8'h00;
            seg_cnt    <= 16'h0000;
            runt_count <= 16'h0000;
            dwp        <= '0;
            drp        <= '0;
            dcnt       <= '0;
            lwp        <= '0;
            lrp        <= '0;
            lcnt       <= '0;
        end else begin
            state <= state_nx;
            if (wr)
                seg_cnt <= wlast ? 16'h0000 : seg_cnt + 16'd1;
            if (state == SRC && wr)
                src <= s_tdata;
            if (state == SEQ && wr)
                seq <= 8'h00;
            else if (state == INS_SEQ && wr)
                seq <= seq + 8'd1;
            if (runt && runt_count != 16'hFFFF)
                runt_count <= runt_count + 16'd1;
            if (wr)
                dwp <= dwp == DAW'(DATA_DEPTH - 1) ? '0 : dwp + 1'b1;
            if (dpop)
                drp <= drp == DAW'(DATA_DEPTH - 1) ? '0 : drp + 1'b1;
            dcnt <= dcnt + (DAW+1)'(wr) - (DAW+1)'(dpop);
            if (len_wr)
                lwp <= lwp == LAW'(LEN_DEPTH - 1) ? '0 : lwp + 1'b1;
            if (lpop)
                lrp <= lrp == LAW'(LEN_DEPTH - 1) ? '0 : lrp + 1'b1;
            lcnt <= lcnt + (LAW+1)'(len_wr) - (LAW+1)'(lpop);
        end
    end
endmodule

// File: tb/tb_udp_segmenter.sv
// tb_udp_segmenter: directed frames against a frame-level segmentation model, with literal pins.
module tb_udp_segmenter;
    localparam int MS = 8;

    logic        clk = 1'b0, resetn = 1'b0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b0, length_tready = 1'b0;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tready, m_tvalid, m_tlast, length_tvalid;
    logic [7:0]  m_tdata;
    logic [15:0] length_tdata, runt_count;

    udp_segmenter #(.MAX_SEG(MS), .DATA_DEPTH(64), .LEN_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .length_tvalid(length_tvalid), .length_tready(length_tready), .length_tdata(length_tdata),
        .runt_count(runt_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [8:0]  exp_b[$], got_b[$], lit[$];
    logic [15:0] exp_l[$], got_l[$];
    logic [7:0]  frm[$];
    int gaps, exp_gaps, sent;
    int mode_m = 1, mode_l = 1;
    logic no_last = 1'b0;

    always @(posedge clk) begin
        m_tready      <= mode_m == 2 ? 1'($urandom % 2) : mode_m == 1;
        length_tready <= mode_l == 2 ? 1'($urandom % 2) : mode_l == 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic       pv_m = 1'b0, pv_l = 1'b0;
    logic [8:0] pd_m;
    logic [15:0] pd_l;
    always @(negedge clk) begin
        if (resetn) begin
            if (pv_m)
                chk("m_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, pd_m});
            if (pv_l)
                chk("len_hold", {length_tvalid, length_tdata}, {1'b1, pd_l});
            if (m_tvalid && m_tready) begin
                if (exp_b.size() == 0) chk("m_unexpected", {m_tlast, m_tdata}, 32'hFFFF_FFFF);
                else chk("m_byte", {m_tlast, m_tdata}, exp_b.pop_front());
                got_b.push_back({m_tlast, m_tdata});
            end
            if (length_tvalid && length_tready) begin
                if (exp_l.size() == 0) chk("len_unexpected", length_tdata, 32'hFFFF_FFFF);
                else chk("len", length_tdata, exp_l.pop_front());
                got_l.push_back(length_tdata);
            end
            pv_m <= m_tvalid && !m_tready;
            pd_m <= {m_tlast, m_tdata};
            pv_l <= length_tvalid && !length_tready;
            pd_l <= length_tdata;
        end else begin
            pv_m <= 1'b0;
            pv_l <= 1'b0;
        end
    end

    // Frame-level model: src, seq, up to MS-2 payload bytes per segment.
    task automatic model();
        int pl, nseg, cnt;
        if (frm.size() < 2) begin
            exp_gaps = 0;
            return;
        end
        pl   = frm.size() - 2;
        nseg = pl == 0 ? 1 : (pl + MS - 3) / (MS - 2);
        for (int s = 0; s < nseg; s++) begin
            cnt = pl - s * (MS - 2);
            if (cnt > MS - 2) cnt = MS - 2;
            exp_b.push_back({1'b0, frm[0]});
            exp_b.push_back({cnt == 0, 8'(s)});
            for (int k = 0; k < cnt; k++)
                exp_b.push_back({k == cnt - 1, frm[2 + s * (MS - 2) + k]});
            exp_l.push_back(16'(cnt + 2));
        end
        exp_gaps = 2 * (nseg - 1);
    endtask

    task automatic send();
        logic hs;
        int t;
        gaps = 0;
        for (int i = 0; i < frm.size(); i++) begin
            s_tvalid = 1'b1;
            s_tdata  = frm[i];
            s_tlast  = !no_last && i == frm.size() - 1;
            t = 0;
            forever begin
                @(negedge clk);
                hs = s_tready;
                @(posedge clk);
                #1;
                if (hs) break;
                gaps++;
                if (++t > 3000) begin
                    chk("send_timeout", 0, 1);
                    s_tvalid = 1'b0;
                    return;
                end
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_frame();
        model();
        send();
        chk("gaps", gaps, exp_gaps);
    endtask

    task automatic drain();
        for (int t = 0; t < 5000 && (exp_b.size() != 0 || exp_l.size() != 0); t++)
            @(posedge clk);
        chk("drain_bytes_left", exp_b.size(), 0);
        chk("drain_lens_left", exp_l.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_lit(input string nm, input int base);
        for (int i = 0; i < lit.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), base + i < got_b.size() ? got_b[base + i] : 9'h1FF, lit[i]);
    endtask

    task automatic clear_logs();
        got_b.delete();
        got_l.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_len_tvalid", length_tvalid, 0);
        chk("rst_runt", runt_count, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_s_tready", s_tready, 1);
        @(posedge clk);
        #1;

        // Single short segment
        clear_logs();
        frm = {8'hA5, 8'hFF, 8'h01, 8'h02, 8'h03};
        run_frame();
        chk("t1_gaps_lit", gaps, 0);
        drain();
        lit = {9'h0A5, 9'h000, 9'h001, 9'h002, 9'h103};
        chk_lit("t1_bytes", 0);
        chk("t1_len_lit", got_l.size() > 0 ? got_l[0] : 16'hFFFF, 5);
        chk("t1_nlen", got_l.size(), 1);

        // Exactly two full segments
        clear_logs();
        frm = {8'h3C, 8'hEE};
        for (int i = 0; i < 12; i++) frm.push_back(8'(i));
        run_frame();
        chk("t2_gaps_lit", gaps, 2);
        drain();
        chk("t2_nlen", got_l.size(), 2);
        chk("t2_len0", got_l.size() > 1 ? {got_l[0], got_l[1]} : 32'hFFFF_FFFF, {16'd8, 16'd8});
        chk("t2_seq1", got_b.size() > 9 ? got_b[9] : 9'h1FF, 9'h001);

        // Three segments, short tail
        clear_logs();
        frm = {8'h3C, 8'h00};
        for (int i = 0; i < 13; i++) frm.push_back(8'(i));
        run_frame();
        chk("t3_gaps_lit", gaps, 4);
        drain();
        lit = {9'h03C, 9'h002, 9'h10C};
        chk_lit("t3_tail", 16);
        chk("t3_len2", got_l.size() > 2 ? got_l[2] : 16'hFFFF, 3);

        // Sequence wrap across 260 segments
        clear_logs();
        frm = {8'h42, 8'h00};
        for (int i = 0; i < 260 * (MS - 2); i++) frm.push_back(8'(i));
        run_frame();
        drain();
        chk("wrap_nlen", got_l.size(), 260);
        chk("wrap_seq_ff", got_b.size() > 2049 ? got_b[255 * 8 + 1] : 9'h1FF, 9'h0FF);
        chk("wrap_seq_00", got_b.size() > 2049 ? got_b[256 * 8 + 1] : 9'h1FF, 9'h000);

        // Runt, then 4-byte and header-only frames
        clear_logs();
        frm = {8'h77};
        run_frame();
        chk("runt_count", runt_count, 1);
        frm = {8'h11, 8'h22, 8'h33, 8'h44};
        run_frame();
        frm = {8'h55, 8'h66};
        run_frame();
        drain();
        lit = {9'h011, 9'h000, 9'h033, 9'h144, 9'h055, 9'h100};
        chk_lit("t4_bytes", 0);
        chk("t4_nbytes", got_b.size(), 6);
        chk("t4_lens", got_l.size() > 1 ? {got_l[0], got_l[1]} : 32'hFFFF_FFFF, {16'd4, 16'd2});
        chk("runt_hold", runt_count, 1);

        // Backpressure fills the 4-entry length FIFO, then random release
        clear_logs();
        mode_m = 0;
        mode_l = 0;
        repeat (2) @(posedge clk);
        #1;
        sent = 0;
        fork
            begin
                for (int f = 0; f < 5; f++) begin
                    frm = {8'(8'h80 + f), 8'hAA, 8'(f), 8'(f + 1), 8'(f + 2)};
                    model();
                    send();
                    sent++;
                end
            end
            begin
                for (int t = 0; t < 500 && sent < 4; t++) @(negedge clk);
                repeat (3) @(negedge clk);
                chk("bp_sent", sent, 4);
                chk("bp_s_tready", s_tready, 0);
                chk("bp_len_tvalid", length_tvalid, 1);
                mode_m = 2;
                mode_l = 2;
            end
        join
        drain();
        mode_m = 1;
        mode_l = 1;
        chk("bp_nlen", got_l.size(), 5);
        chk("bp_nbytes", got_b.size(), 25);

        // Reset mid-payload discards the partial segment
        mode_m = 0;
        repeat (2) @(posedge clk);
        #1;
        no_last = 1'b1;
        frm = {8'h99, 8'h00, 8'h01, 8'h02};
        send();
        no_last = 1'b0;
        @(negedge clk);
        chk("pre_rst_m_tvalid", m_tvalid, 1);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("mid_rst_m_tvalid", m_tvalid, 0);
        chk("mid_rst_len_tvalid", length_tvalid, 0);
        chk("mid_rst_s_tready", s_tready, 1);
        mode_m = 1;
        @(posedge clk);
        #1;
        clear_logs();
        frm = {8'h99, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        run_frame();
        drain();
        chk("t6_seq0", got_b.size() > 1 ? got_b[1] : 9'h1FF, 9'h000);
        chk("t6_lens", got_l.size() > 1 ? {got_l[0], got_l[1]} : 32'hFFFF_FFFF, {16'd8, 16'd3});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
